// File: rtl/pmos_arb_pkg.sv
// Shared types, parameter bounds and sizing helpers for the pmos bus arbiter.
package pmos_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StDead
  } arb_state_e;

  localparam int unsigned NReqMin       = 2;
  localparam int unsigned NReqMax       = 16;
  localparam int unsigned DeadCyclesMin = 1;
  localparam int unsigned DeadCyclesMax = 15;
  localparam int unsigned MaxHoldMin    = 1;

  // Bits needed for a counter that must reach max_val.
  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pmos_bus_arbiter_if.sv
// Requester/arbiter bundle: level-held requests in, registered gate controls out.
interface pmos_bus_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned IdxW = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] gate_n;
  logic             busy;
  logic [IdxW-1:0]  owner;
  logic             timeout_err;

  modport master (
    input  req,
    output gnt,
    output gate_n,
    output busy,
    output owner,
    output timeout_err
  );

  modport slave (
    output req,
    input  gnt,
    input  gate_n,
    input  busy,
    input  owner,
    input  timeout_err
  );

endinterface

// File: rtl/pmos_arb_rr_pick.sv
// Rotating-priority picker: first set request strictly after `last`, wrapping modulo N_REQ.
module pmos_arb_rr_pick #(
  parameter int unsigned  N_REQ = 4,
  localparam int unsigned IdxW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  last,
  output logic             valid,
  output logic [IdxW-1:0]  idx
);

  int unsigned cand;

  // Walk from the farthest candidate inward so the nearest one wins.
  always_comb begin
    valid = 1'b0;
    idx   = last;
    cand  = 0;
    for (int off = N_REQ; off > 0; off--) begin
      cand = (32'(last) + 32'(off)) % N_REQ;
      if (req[IdxW'(cand)]) begin
        valid = 1'b1;
        idx   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/pmos_bus_arbiter.sv
// Round-robin owner sequencing for pmos pass gates with break-before-make dead cycles.
// Optional forced release after MAX_HOLD grant cycles when PMOS_ARB_TIMEOUT_EN is defined.
module pmos_bus_arbiter
  import pmos_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DEAD_CYCLES = 1,
  parameter int unsigned MAX_HOLD    = 16
) (
  input logic                clk,
  input logic                rst_n,
  pmos_bus_arbiter_if.master bus
);

  localparam int unsigned IdxW  = $clog2(N_REQ);
  localparam int unsigned DeadW = cnt_width(DEAD_CYCLES);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] gate_n_q;
  logic [N_REQ-1:0] eligible;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_valid;
  logic [DeadW-1:0] dead_cnt_q, dead_cnt_d;

`ifdef PMOS_ARB_TIMEOUT_EN
  localparam int unsigned HoldW = cnt_width(MAX_HOLD);

  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] blocked_q, blocked_d;
  logic             terr_q, terr_d;

  // A timed-out requester stays ineligible until it has dropped its request.
  assign eligible = bus.req & ~blocked_q;
`else
  assign eligible = bus.req;
`endif

  pmos_arb_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (eligible),
    .last  (owner_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    dead_cnt_d = dead_cnt_q;
`ifdef PMOS_ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    terr_d     = 1'b0;
    blocked_d  = blocked_q & bus.req;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          owner_d         = pick_idx;
          state_d         = StGrant;
`ifdef PMOS_ARB_TIMEOUT_EN
          hold_cnt_d      = '0;
`endif
        end
      end
      StGrant: begin
        if (!bus.req[owner_q]) begin
          gnt_d      = '0;
          dead_cnt_d = '0;
          state_d    = StDead;
        end
`ifdef PMOS_ARB_TIMEOUT_EN
        else if (hold_cnt_q == HoldW'(MAX_HOLD - 1)) begin
          gnt_d              = '0;
          dead_cnt_d         = '0;
          state_d            = StDead;
          terr_d             = 1'b1;
          blocked_d[owner_q] = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
      end
      StDead: begin
        if (dead_cnt_q == DeadW'(DEAD_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          dead_cnt_d = dead_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      gate_n_q   <= '1;
      owner_q    <= IdxW'(N_REQ - 1);
      dead_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gate_n_q   <= ~gnt_d;
      owner_q    <= owner_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

`ifdef PMOS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      blocked_q  <= '0;
      terr_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      blocked_q  <= blocked_d;
      terr_q     <= terr_d;
    end
  end

  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.gnt    = gnt_q;
  assign bus.gate_n = gate_n_q;
  assign bus.busy   = (state_q != StIdle);
  assign bus.owner  = owner_q;

  // At most one pmos may conduct, and the gate drive must mirror the grant exactly.
  a_one_gate: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q) && (gate_n_q == ~gnt_q));

  a_params_legal: assert property (@(posedge clk)
    (N_REQ >= NReqMin) && (N_REQ <= NReqMax) &&
    (DEAD_CYCLES >= DeadCyclesMin) && (DEAD_CYCLES <= DeadCyclesMax) &&
    (MAX_HOLD >= MaxHoldMin));

endmodule

// File: tb/tb_pmos_bus_arbiter.sv
// Self-checking bench for pmos_bus_arbiter: directed table, corner sequences, random vs model.
// Covers the PMOS_ARB_TIMEOUT_EN build as well as the default build.
module tb_pmos_bus_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned DEAD = 1;
  localparam int unsigned MAXH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pmos_bus_arbiter_if #(.N_REQ(N)) bus ();

  pmos_bus_arbiter #(
    .N_REQ       (N),
    .DEAD_CYCLES (DEAD),
    .MAX_HOLD    (MAXH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the net, how many dead cycles remain, how long held.
  bit           m_granted;
  int           m_owner;
  int           m_dead_left;
  int           m_hold;
  bit           m_terr;
  logic [N-1:0] m_blocked;

  typedef struct packed {
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         busy;
  } vec_t;

  vec_t tbl [18];

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_granted) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_granted   = 1'b0;
    m_owner     = N - 1;
    m_dead_left = 0;
    m_hold      = 0;
    m_terr      = 1'b0;
    m_blocked   = '0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    m_terr = 1'b0;
    if (m_granted) begin
      if (!r[m_owner]) begin
        m_granted   = 1'b0;
        m_dead_left = DEAD;
      end
`ifdef PMOS_ARB_TIMEOUT_EN
      else if (m_hold == MAXH) begin
        m_granted   = 1'b0;
        m_dead_left = DEAD;
        m_terr      = 1'b1;
      end else begin
        m_hold++;
      end
`endif
    end else if (m_dead_left > 0) begin
      m_dead_left--;
    end else begin
      for (int off = 1; off <= N; off++) begin
        int i;
        i = (m_owner + off) % N;
        if (r[i] && !m_blocked[i]) begin
          m_owner   = i;
          m_granted = 1'b1;
          m_hold    = 1;
          break;
        end
      end
    end
    m_blocked = m_blocked & r;
    if (m_terr) m_blocked[m_owner] = 1'b1;
  endtask

  // Apply req for one clock edge, then compare every output with the model.
  task automatic tick(input logic [N-1:0] r);
    logic [N-1:0] eg, eg_n;
    bus.req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    eg   = m_gnt();
    eg_n = ~eg;
    check("gnt", bus.gnt, eg);
    check("gate_n", bus.gate_n, eg_n);
    check("busy", bus.busy, m_granted || (m_dead_left > 0));
    check("owner", bus.owner, m_owner);
    check("timeout_err", bus.timeout_err, m_terr);
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    check("rst gnt", bus.gnt, 0);
    check("rst gate_n", bus.gate_n, 4'b1111);
    check("rst busy", bus.busy, 0);
    check("rst owner", bus.owner, N - 1);
    check("rst timeout_err", bus.timeout_err, 0);
  endtask

  int           got, gap, hold, cnt_a, cnt_b;
  bit           seen;
  logic [N-1:0] r;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req = '0;
    tbl = '{
      '{4'b0000, 4'b0000, 1'b0}, '{4'b0000, 4'b0000, 1'b0},
      '{4'b0001, 4'b0001, 1'b1}, '{4'b0001, 4'b0001, 1'b1},
      '{4'b0000, 4'b0000, 1'b1}, '{4'b0000, 4'b0000, 1'b0},
      '{4'b0110, 4'b0010, 1'b1}, '{4'b0100, 4'b0000, 1'b1},
      '{4'b0100, 4'b0000, 1'b0}, '{4'b0100, 4'b0100, 1'b1},
      '{4'b1100, 4'b0100, 1'b1}, '{4'b1000, 4'b0000, 1'b1},
      '{4'b1000, 4'b0000, 1'b0}, '{4'b1000, 4'b1000, 1'b1},
      '{4'b1001, 4'b1000, 1'b1}, '{4'b0001, 4'b0000, 1'b1},
      '{4'b0001, 4'b0000, 1'b0}, '{4'b0001, 4'b0001, 1'b1}
    };

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 10; i++) tick(4'b0000);

    // Directed table
    do_reset();
    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].req);
      check($sformatf("tbl[%0d].gnt", i), bus.gnt, tbl[i].gnt);
      check($sformatf("tbl[%0d].busy", i), bus.busy, tbl[i].busy);
    end

    // All requesting; each owner keeps the net 3 cycles then releases once
    do_reset();
    got = 0; gap = 0; hold = 0; r = 4'b1111;
    for (int c = 0; c < 200 && got < 5; c++) begin
      tick(r);
      if (bus.gnt != '0) begin
        if (hold == 0) begin
          check("rr order", bus.owner, got % N);
          if (got > 0) check("rr gap", gap, DEAD + 1);
          got++;
          gap = 0;
        end
        hold++;
        r = (hold == 3) ? (4'b1111 & ~bus.gnt) : 4'b1111;
      end else begin
        gap++;
        hold = 0;
        r = 4'b1111;
      end
    end
    check("rr grants", got, 5);

    // Owner 2 drops in the same cycle req[1] rises
    do_reset();
    tick(4'b0100);
    check("own2 gnt", bus.gnt, 4'b0100);
    tick(4'b0100);
    tick(4'b0010);
    check("drop gnt", bus.gnt, 4'b0000);
    tick(4'b0010);
    check("dead gap gnt", bus.gnt, 4'b0000);
    tick(4'b0010);
    check("handover gnt", bus.gnt, 4'b0010);

    // Asynchronous reset mid-grant opens every gate before the next edge
    #2 rst_n = 1'b0;
    #1;
    check("async gate_n", bus.gate_n, 4'b1111);
    check("async gnt", bus.gnt, 4'b0000);
    check("async owner", bus.owner, N - 1);
    @(negedge clk);
    bus.req = '0;
    model_reset();
    rst_n = 1'b1;
    tick(4'b0100);
    check("post rst gnt", bus.gnt, 4'b0100);

    // Long hold by requester 0 with requester 3 waiting
    do_reset();
    tick(4'b0001);
`ifdef PMOS_ARB_TIMEOUT_EN
    cnt_a = 1; cnt_b = 0; seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick(4'b1001);
      if (bus.gnt[0]) cnt_a++;
      if (bus.timeout_err) begin
        cnt_b++;
        check("terr gnt clear", bus.gnt, 4'b0000);
      end
      if (bus.gnt[3]) begin
        seen = 1'b1;
        break;
      end
    end
    check("hold cycles", cnt_a, MAXH);
    check("terr pulses", cnt_b, 1);
    check("pending 3 granted", seen, 1);
    cnt_a = 0;
    for (int c = 0; c < 10; c++) begin
      tick(4'b0001);
      if (bus.gnt[0]) cnt_a++;
    end
    check("no regrant", cnt_a, 0);
    tick(4'b0000);
    tick(4'b0001);
    check("regrant after toggle", bus.gnt, 4'b0001);
`else
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 1000; c++) begin
      tick(4'b1001);
      if (bus.gnt == 4'b0001) cnt_a++;
      if (bus.timeout_err) cnt_b++;
    end
    check("held cycles", cnt_a, 1000);
    check("terr count", cnt_b, 0);
`endif

    // Random request traffic against the model
    do_reset();
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) r = N'($urandom);
      tick(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
